// File: rtl/drive_seq_pkg.sv
// Shared types and constants for the line-following drive sequencer.
// The mode codes are also decoded by the motor block, so keep them in step.
package drive_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    SEARCH = 3'd4,
    HALT   = 3'd5,
    LOST   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    LINE_NONE  = 2'd0,
    LINE_FWD   = 2'd1,
    LINE_LEFT  = 2'd2,
    LINE_RIGHT = 2'd3
  } line_t;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_FWD   = 2'b11;

  // Map filtered {left, centre, right} tracker bits to a steering direction.
  function automatic line_t decode_line(input logic [2:0] sens);
    line_t dir;
    case (sens)
      3'b010, 3'b111, 3'b101: dir = LINE_FWD;
      3'b100, 3'b110:         dir = LINE_LEFT;
      3'b001, 3'b011:         dir = LINE_RIGHT;
      default:                dir = LINE_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Handshake bundle between the sequencer and its surroundings:
// run/stop requests and raw tracker bits in, motor mode and status out.
interface drive_sequencer_if;

  logic       enable;
  logic       obstacle;
  logic [2:0] sensor;
  logic [1:0] mode;
  logic       lost;
  logic [2:0] state_dbg;

  modport master (
    output enable, obstacle, sensor,
    input  mode, lost, state_dbg
  );

  modport slave (
    input  enable, obstacle, sensor,
    output mode, lost, state_dbg
  );

endinterface

// File: rtl/sensor_debounce.sv
// One tracker bit: two-flop synchroniser followed by a debounce filter.
// The filtered bit only follows the synchronised input after CYCLES
// consecutive cycles of disagreement; any agreeing cycle restarts the count.
module sensor_debounce #(
  parameter int CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int W = $clog2(CYCLES) + 1;

  logic         sync1;
  logic         sync2;
  logic [W-1:0] cnt;

  // Bring the asynchronous tracker bit into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count disagreeing cycles and accept the new level once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (sync2 != filtered) begin
      if (cnt == W'(CYCLES - 1)) begin
        filtered <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: filters the tracker bits, picks a steering
// state with a minimum dwell, handles obstacle halts and lost-line search, and
// registers the motor mode from the next state so it moves with the state.
module drive_sequencer
  import drive_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int MIN_DWELL       = 2_000_000,
  parameter int LOST_TIMEOUT    = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  drive_sequencer_if.slave  bus
);

  localparam int DW = $clog2(MIN_DWELL) + 1;
  localparam int LW = $clog2(LOST_TIMEOUT) + 1;

  logic [2:0]    filt;
  line_t         line;
  state_t        state;
  state_t        next_state;
  state_t        line_target;
  logic [DW-1:0] dwell;
  logic [LW-1:0] lost_cnt;
  logic [1:0]    last_turn;
  logic [1:0]    last_turn_next;
  logic [1:0]    mode_next;
  logic          dwell_done;
  logic          search_timeout;

  for (genvar i = 0; i < 3; i++) begin : g_sens
    sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (bus.sensor[i]),
      .filtered (filt[i])
    );
  end

  assign line           = decode_line(filt);
  assign dwell_done     = (dwell >= DW'(MIN_DWELL));
  assign search_timeout = (lost_cnt == LW'(LOST_TIMEOUT - 1));

  // Next state by priority: disable, obstacle, search timeout, then the line.
  always_comb begin
    next_state  = state;
    line_target = SEARCH;
    case (line)
      LINE_FWD:   line_target = FWD;
      LINE_LEFT:  line_target = LEFT;
      LINE_RIGHT: line_target = RIGHT;
      default:    line_target = SEARCH;
    endcase
    if (!bus.enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (!bus.obstacle) next_state = FWD;
        HALT: if (!bus.obstacle) next_state = IDLE;
        FWD, LEFT, RIGHT: begin
          if (bus.obstacle)
            next_state = HALT;
          else if (dwell_done && line_target != state)
            next_state = line_target;
        end
        SEARCH: begin
          if (bus.obstacle)
            next_state = HALT;
          else if (search_timeout)
            next_state = LOST;
          else if (line != LINE_NONE)
            next_state = line_target;
        end
        LOST:    next_state = LOST;
        default: next_state = IDLE;
      endcase
    end
  end

  // Remember the last turn taken and derive the motor mode of the next state.
  always_comb begin
    last_turn_next = last_turn;
    mode_next      = MODE_STOP;
    if (next_state != state && next_state == LEFT)  last_turn_next = MODE_LEFT;
    if (next_state != state && next_state == RIGHT) last_turn_next = MODE_RIGHT;
    case (next_state)
      FWD:     mode_next = MODE_FWD;
      LEFT:    mode_next = MODE_LEFT;
      RIGHT:   mode_next = MODE_RIGHT;
      SEARCH:  mode_next = last_turn_next;
      default: mode_next = MODE_STOP;
    endcase
  end

  // State register plus the registered outputs that track it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_turn     <= MODE_LEFT;
      bus.mode      <= MODE_STOP;
      bus.lost      <= 1'b0;
      bus.state_dbg <= IDLE;
    end else begin
      state         <= next_state;
      last_turn     <= last_turn_next;
      bus.mode      <= mode_next;
      bus.lost      <= (next_state == LOST);
      bus.state_dbg <= next_state;
    end
  end

  // Dwell restarts on every state change and saturates; search count restarts on SEARCH entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell    <= '0;
      lost_cnt <= '0;
    end else begin
      if (next_state != state)
        dwell <= '0;
      else if (!dwell_done)
        dwell <= dwell + DW'(1);
      if (next_state == SEARCH && state != SEARCH)
        lost_cnt <= '0;
      else if (state == SEARCH && !search_timeout)
        lost_cnt <= lost_cnt + LW'(1);
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer: directed scenarios then random
// sensor/enable/obstacle traffic, compared every cycle to a rule-level model.
module tb_drive_sequencer;
  import drive_seq_pkg::*;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int LT    = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  drive_sequencer_if bus ();

  drive_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .MIN_DWELL       (DWELL),
    .LOST_TIMEOUT    (LT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: raw sample history, filtered bits, state and entry time.
  logic [2:0] raw_hist [0:7];
  logic [2:0] m_filt;
  state_t     m_state;
  logic [1:0] m_turn;
  int         edge_n;
  int         entry_edge;

  function automatic state_t line_dir(input logic [2:0] s);
    if (s == 3'b000)   return SEARCH;
    if (s[2] == s[0])  return FWD;
    if (s[2])          return LEFT;
    return RIGHT;
  endfunction

  function automatic logic [1:0] exp_mode();
    case (m_state)
      FWD:     return 2'b11;
      LEFT:    return 2'b10;
      RIGHT:   return 2'b01;
      SEARCH:  return m_turn;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 8; j++) raw_hist[j] = 3'b000;
    m_filt     = 3'b000;
    m_state    = IDLE;
    m_turn     = 2'b10;
    edge_n     = 0;
    entry_edge = 0;
  endtask

  task automatic model_edge();
    state_t nxt;
    state_t dir;
    int     in_state;
    bit     all_diff;
    edge_n++;
    in_state = edge_n - entry_edge - 1;
    dir      = line_dir(m_filt);
    nxt      = m_state;
    if (!bus.enable) nxt = IDLE;
    else begin
      case (m_state)
        IDLE: if (!bus.obstacle) nxt = FWD;
        HALT: if (!bus.obstacle) nxt = IDLE;
        FWD, LEFT, RIGHT:
          if (bus.obstacle) nxt = HALT;
          else if (in_state >= DWELL && dir != m_state) nxt = dir;
        SEARCH:
          if (bus.obstacle) nxt = HALT;
          else if (in_state == LT - 1) nxt = LOST;
          else if (dir != SEARCH) nxt = dir;
        default: nxt = m_state;
      endcase
    end
    if (nxt != m_state) begin
      entry_edge = edge_n;
      if (nxt == LEFT)  m_turn = 2'b10;
      if (nxt == RIGHT) m_turn = 2'b01;
    end
    m_state = nxt;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= DEB; j++)
        if (raw_hist[j][b] == m_filt[b]) all_diff = 1'b0;
      if (all_diff) m_filt[b] = ~m_filt[b];
    end
    for (int j = 7; j > 0; j--) raw_hist[j] = raw_hist[j-1];
    raw_hist[0] = bus.sensor;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".mode"},  {6'b0, bus.mode},      {6'b0, exp_mode()});
    check({tag, ".lost"},  {7'b0, bus.lost},      {7'b0, (m_state == LOST)});
    check({tag, ".state"}, {5'b0, bus.state_dbg}, {5'b0, m_state});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic en, input logic obs, input logic [2:0] sens,
                               input int n, input string tag);
    bus.enable   = en;
    bus.obstacle = obs;
    bus.sensor   = sens;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    model_reset();
    rst_n        = 1'b0;
    bus.enable   = 1'b1;
    bus.obstacle = 1'b0;
    bus.sensor   = 3'b010;
    #1;
    check("reset.mode",  {6'b0, bus.mode},      8'h00);
    check("reset.lost",  {7'b0, bus.lost},      8'h00);
    check("reset.state", {5'b0, bus.state_dbg}, {5'b0, IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start: FWD one edge after release, stays FWD after the filter settles.
    applyStimulus(1'b1, 1'b0, 3'b010, 1, "start");
    check("start.first_edge", {6'b0, bus.mode}, 8'h03);
    applyStimulus(1'b1, 1'b0, 3'b010, 14, "start");
    check("start.settled", {6'b0, bus.mode}, 8'h03);

    // Debounce: short glitches towards 100 must be ignored.
    applyStimulus(1'b1, 1'b0, 3'b100, 2, "glitch");
    applyStimulus(1'b1, 1'b0, 3'b010, 2, "glitch");
    applyStimulus(1'b1, 1'b0, 3'b100, 2, "glitch");
    applyStimulus(1'b1, 1'b0, 3'b010, 2, "glitch");
    check("glitch.ignored", {6'b0, bus.mode}, 8'h03);
    applyStimulus(1'b1, 1'b0, 3'b100, 6, "debounce");
    check("debounce.not_yet", {6'b0, bus.mode}, 8'h03);
    applyStimulus(1'b1, 1'b0, 3'b100, 1, "debounce");
    check("debounce.left", {6'b0, bus.mode}, 8'h02);

    // Dwell hold: decode flips to RIGHT early, mode holds LEFT until dwell ends.
    applyStimulus(1'b1, 1'b0, 3'b001, 8, "dwell");
    check("dwell.hold", {6'b0, bus.mode}, 8'h02);
    applyStimulus(1'b1, 1'b0, 3'b001, 1, "dwell");
    check("dwell.right", {6'b0, bus.mode}, 8'h01);

    // Lost line from RIGHT: SEARCH steering right, then LOST after the timeout.
    applyStimulus(1'b1, 1'b0, 3'b000, 9, "search");
    check("search.state", {5'b0, bus.state_dbg}, {5'b0, SEARCH});
    check("search.mode",  {6'b0, bus.mode},      8'h01);
    applyStimulus(1'b1, 1'b0, 3'b000, 19, "search");
    check("search.not_lost", {7'b0, bus.lost}, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b000, 1, "lost");
    check("lost.flag", {7'b0, bus.lost}, 8'h01);
    check("lost.mode", {6'b0, bus.mode}, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'b010, 15, "lost");
    check("lost.sticky", {7'b0, bus.lost}, 8'h01);
    applyStimulus(1'b0, 1'b0, 3'b010, 1, "restart");
    check("restart.idle", {5'b0, bus.state_dbg}, {5'b0, IDLE});
    applyStimulus(1'b1, 1'b0, 3'b010, 1, "restart");
    check("restart.fwd", {6'b0, bus.mode}, 8'h03);

    // Obstacle: halt next edge, release goes via IDLE back to FWD.
    applyStimulus(1'b1, 1'b0, 3'b010, 10, "obst");
    applyStimulus(1'b1, 1'b1, 3'b010, 1, "obst");
    check("obst.halt", {5'b0, bus.state_dbg}, {5'b0, HALT});
    applyStimulus(1'b1, 1'b1, 3'b010, 3, "obst");
    applyStimulus(1'b1, 1'b0, 3'b010, 1, "obst");
    check("obst.idle", {5'b0, bus.state_dbg}, {5'b0, IDLE});
    applyStimulus(1'b1, 1'b0, 3'b010, 1, "obst");
    check("obst.fwd", {6'b0, bus.mode}, 8'h03);
    applyStimulus(1'b1, 1'b0, 3'b010, 3, "obst");
    applyStimulus(1'b0, 1'b1, 3'b010, 1, "obst_dis");
    check("obst_dis.idle", {5'b0, bus.state_dbg}, {5'b0, IDLE});
    applyStimulus(1'b1, 1'b0, 3'b010, 12, "obst");

    // Asynchronous reset in the middle of SEARCH.
    applyStimulus(1'b1, 1'b0, 3'b000, 12, "areset");
    check("areset.search", {5'b0, bus.state_dbg}, {5'b0, SEARCH});
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.mode",  {6'b0, bus.mode},      8'h00);
    check("areset.lost",  {7'b0, bus.lost},      8'h00);
    check("areset.state", {5'b0, bus.state_dbg}, {5'b0, IDLE});
    model_reset();
    bus.sensor = 3'b100;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b100, 12, "after_rst");
    applyStimulus(1'b1, 1'b0, 3'b000, 35, "after_rst");

    // Random traffic against the model.
    for (int it = 0; it < 250; it++) begin
      logic en;
      logic ob;
      en = ($urandom_range(15) != 0);
      ob = ($urandom_range(9) == 0);
      applyStimulus(en, ob, 3'($urandom_range(7)), $urandom_range(12, 1), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Line-following drive controller that sequences the two-motor drive block. It synchronises and debounces the three line-tracker sensors and applies a minimum dwell time to every drive decision. It also handles obstacle halts and lost-line search/timeout, and produces the 2-bit `mode` that the motor block decodes into PWM duty and direction.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: consecutive stable cycles before a sensor bit is accepted (1 ms at 100 MHz).
- `MIN_DWELL`, default 2_000_000: minimum cycles spent in FWD/LEFT/RIGHT before a line-driven change (20 ms).
- `LOST_TIMEOUT`, default 50_000_000: cycles in SEARCH before declaring the line lost (0.5 s).
- `clk`, in, 1: 100 MHz system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: run request, synchronous to `clk`.
- `obstacle`, in, 1: stop request from the distance sensor, synchronous to `clk`.
- `sensor`, in, 3: raw tracker bits {left, centre, right}, asynchronous, 1 = line seen.
- `mode`, out, 2: to motor block. 00 = stop, 01 = veer right, 10 = veer left, 11 = forward.
- `lost`, out, 1: high while in LOST.
- `state_dbg`, out, 3: current state encoding, for LEDs.

## Operation
- Sensor path per bit: 2-flop synchroniser, then debounce.
  - Debounce: filtered bit takes the synchronised value after `DEBOUNCE_CYCLES` consecutive cycles of a value different from the filtered bit.
  - Any glitch restarts the count.
- Direction decode of filtered {l,c,r}:
  - 010, 111, 101 -> FWD.
  - 100, 110 -> LEFT.
  - 001, 011 -> RIGHT.
  - 000 -> none.
- States and their `mode` output: IDLE 00, FWD 11, LEFT 10, RIGHT 01, SEARCH (`last_turn`: 10 or 01), HALT 00, LOST 00.
- Transition priority, highest first:
  1. `!enable`: any state -> IDLE.
  2. `obstacle`: FWD/LEFT/RIGHT/SEARCH -> HALT.
  3. SEARCH timeout: SEARCH -> LOST.
  4. Line-driven changes.
- IDLE -> FWD when `enable && !obstacle`.
- HALT -> IDLE when `obstacle == 0`. Normal IDLE restart follows on the next edge.
- FWD/LEFT/RIGHT:
  - Move to the decoded direction only when `dwell >= MIN_DWELL` and the decode differs from the current state.
  - Decode "none" with dwell satisfied -> SEARCH.
- SEARCH:
  - Any non-none decode -> that direction immediately, with no dwell check.
  - `lost_cnt == LOST_TIMEOUT-1` -> LOST.
- LOST: exited only through `!enable` (-> IDLE).
- `last_turn` is updated on entry to LEFT or RIGHT. It is unchanged by FWD. Reset value LEFT.
- Counters:
  - `dwell` clears on every state entry and saturates at `MIN_DWELL`.
  - `lost_cnt` clears on SEARCH entry.
  - Width `$clog2` of the parameter + 1. No wrap.

## Timing
- Reset values:
  - `mode` = 00, `lost` = 0, `state_dbg` = IDLE.
  - Filtered sensors = 000, sync flops = 0.
  - All counters 0, `last_turn` = LEFT.
- Reset asserted mid-operation forces these values immediately (asynchronously). Deassertion takes effect at the next `clk` edge.
- `mode`, `lost` and `state_dbg` are registered and decoded from next-state, so they change on the same edge as the state register.
- `enable`/`obstacle` -> `mode` change: 1 edge.
- Raw sensor edge -> filtered change: 2 + `DEBOUNCE_CYCLES` edges. The state may then change on the following edge, subject to dwell.
- Simultaneous `!enable` and `obstacle` -> IDLE.
- Dwell expiry in the same cycle as a decode change -> transition taken that edge.
- Line reappearing on the timeout cycle -> LOST wins.

## Structure
- Package `drive_seq_pkg`:
  - State enum (IDLE, FWD, LEFT, RIGHT, SEARCH, HALT, LOST; 3 bits).
  - Mode constants `MODE_STOP` = 00, `MODE_RIGHT` = 01, `MODE_LEFT` = 10, `MODE_FWD` = 11, shared with the motor block.
- Sub-module `sensor_debounce`: parameter `CYCLES`, 1-bit, contains sync and counter. Instantiated three times.
- The top contains the decode, FSM, counters and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `MIN_DWELL` = 8, `LOST_TIMEOUT` = 20.
- Reset and start: reset released with `enable`=1, `sensor`=010. `mode`=11 one edge after reset release, then stays 11 after the filter settles.
- Debounce: `sensor` 010 -> 100 with 2-cycle glitches back to 010. No change until 100 is held 4 cycles, then `mode`=10, only once dwell ≥ 8.
- Dwell hold: in LEFT, `sensor` 100 -> 001 at dwell 3. `mode` stays 10 until dwell reaches 8, then 01.
- Lost line: from RIGHT, `sensor`=000 held.
  - SEARCH with `mode`=01.
  - After 20 cycles `mode`=00 and `lost`=1.
  - `sensor`=010 afterwards does not restart; `enable` 0 -> 1 does (IDLE -> FWD).
- Obstacle: `obstacle`=1 in FWD -> `mode`=00 next edge. Release -> IDLE, then FWD (11) 2 edges later. `obstacle` with `enable`=0 on the same cycle -> IDLE.
- Async reset mid-SEARCH: `rst_n` pulled low between edges -> `mode`=00 and `lost`=0 without waiting for `clk`. Counters restart from 0 after release.
